// File: rtl/qc_addr_gen_pkg.sv
// Shared types and helpers for the QC-LDPC multi-channel address generator.
package qc_addr_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width needed to hold circulant sizes 0..max_z.
   function automatic int zw_of(input int max_z);
      return $clog2(max_z + 1);
   endfunction

   // Bit offset of channel c inside a packed per-channel bus with field width w.
   function automatic int ch_lo(input int c, input int w);
      return c * w;
   endfunction

endpackage

// File: rtl/qc_wrap_cnt.sv
// Modulo-z_len circulant offset counter for one channel.
// Reverse stepping exists only when QC_ADDR_GEN_REVERSE_EN is defined.
module qc_wrap_cnt #(
   parameter int ZW = 7
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          load,
   input  logic          step,
   input  logic [ZW-1:0] load_val,
   input  logic [ZW-1:0] z_len,
`ifdef QC_ADDR_GEN_REVERSE_EN
   input  logic          reverse,
`endif
   output logic [ZW-1:0] off
);

   logic [ZW-1:0] top;
   logic [ZW-1:0] off_n;

   assign top = z_len - ZW'(1);

   always_comb begin
      off_n = off;
      if (load) begin
         off_n = load_val;
      end else if (step) begin
`ifdef QC_ADDR_GEN_REVERSE_EN
         if (reverse) begin
            off_n = (off == '0) ? top : off - ZW'(1);
         end else begin
            off_n = (off == top) ? '0 : off + ZW'(1);
         end
`else
         off_n = (off == top) ? '0 : off + ZW'(1);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         off <= '0;
      end else if (enable) begin
         off <= off_n;
      end
   end

endmodule

// File: rtl/qc_addr_gen.sv
// Multi-channel QC-LDPC circulant address generator (valid/ready stream).
// Optional backward sweep via QC_ADDR_GEN_REVERSE_EN (adds the reverse input).
module qc_addr_gen
   import qc_addr_gen_pkg::*;
#(
   parameter int NUM_BITS = 8,
   parameter int NUM_CH   = 4,
   parameter int MAX_Z    = 64,
   localparam int ZW      = zw_of(MAX_Z)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       start,
   input  logic [ZW-1:0]              z_len,
   input  logic [NUM_CH*NUM_BITS-1:0] base_addr,
   input  logic [NUM_CH*ZW-1:0]       shift,
`ifdef QC_ADDR_GEN_REVERSE_EN
   input  logic                       reverse,
`endif
   input  logic                       addr_ready,
   output logic                       addr_valid,
   output logic [NUM_CH*NUM_BITS-1:0] address,
   output logic [ZW-1:0]              index,
   output logic                       last,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   state_t                     state, state_n;
   logic [ZW-1:0]              zl;
   logic [ZW-1:0]              k;
   logic [NUM_CH*NUM_BITS-1:0] base_q;
   logic [ZW-1:0]              off      [NUM_CH];
   logic [ZW-1:0]              load_val [NUM_CH];
   logic [NUM_CH-1:0]          shift_bad;
   logic                       z_bad;
   logic                       is_last;
   logic                       load;
   logic                       step;
   logic                       err_set;
`ifdef QC_ADDR_GEN_REVERSE_EN
   logic                       rev_q;
`endif

   assign z_bad   = (z_len == '0) || (z_len > ZW'(MAX_Z));
   assign is_last = (k == zl - ZW'(1));

   // IDLE and DONE share start handling so a start in DONE chains straight into RUN.
   always_comb begin
      state_n = state;
      load    = 1'b0;
      step    = 1'b0;
      err_set = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            state_n = IDLE;
            if (start) begin
               if (z_bad) begin
                  err_set = 1'b1;
               end else begin
                  load    = 1'b1;
                  err_set = |shift_bad;
                  state_n = RUN;
               end
            end
         end
         RUN: begin
            if (addr_ready) begin
               if (is_last) begin
                  state_n = DONE;
               end else begin
                  step = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         zl     <= '0;
         k      <= '0;
         base_q <= '0;
         err    <= 1'b0;
`ifdef QC_ADDR_GEN_REVERSE_EN
         rev_q  <= 1'b0;
`endif
      end else if (enable) begin
         state <= state_n;
         if (load) begin
            zl     <= z_len;
            base_q <= base_addr;
            k      <= '0;
`ifdef QC_ADDR_GEN_REVERSE_EN
            rev_q  <= reverse;
`endif
         end else if (step) begin
            k <= k + ZW'(1);
         end
         if (err_set) begin
            err <= 1'b1;
         end
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [ZW-1:0] sh;

      assign sh           = shift[ch_lo(c, ZW) +: ZW];
      assign shift_bad[c] = (sh >= z_len);
      assign load_val[c]  = shift_bad[c] ? '0 : sh;

      qc_wrap_cnt #(
         .ZW(ZW)
      ) u_cnt (
         .clk      (clk),
         .reset    (reset),
         .enable   (enable),
         .load     (load),
         .step     (step),
         .load_val (load_val[c]),
         .z_len    (zl),
`ifdef QC_ADDR_GEN_REVERSE_EN
         .reverse  (rev_q),
`endif
         .off      (off[c])
      );

      assign address[ch_lo(c, NUM_BITS) +: NUM_BITS] =
         base_q[ch_lo(c, NUM_BITS) +: NUM_BITS] + NUM_BITS'(off[c]);
   end

   // Outputs decode only registered state, so no input reaches an output combinationally.
   assign addr_valid = (state == RUN);
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);
   assign last       = (state == RUN) && is_last;
   assign index      = k;

endmodule

// File: tb/tb_qc_addr_gen.sv
// Directed self-checking bench for qc_addr_gen (NUM_CH=4, NUM_BITS=8, MAX_Z=64).
module tb_qc_addr_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        start;
   logic [6:0]  z_len;
   logic [31:0] base_addr;
   logic [27:0] shift;
`ifdef QC_ADDR_GEN_REVERSE_EN
   logic        reverse;
`endif
   logic        addr_ready;
   logic        addr_valid;
   logic [31:0] address;
   logic [6:0]  index;
   logic        last;
   logic        busy;
   logic        done;
   logic        err;

   int errors = 0;
   int checks = 0;
   int xfers  = 0;

   always #5 clk = ~clk;

   qc_addr_gen #(
      .NUM_BITS (8),
      .NUM_CH   (4),
      .MAX_Z    (64)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .start      (start),
      .z_len      (z_len),
      .base_addr  (base_addr),
      .shift      (shift),
`ifdef QC_ADDR_GEN_REVERSE_EN
      .reverse    (reverse),
`endif
      .addr_ready (addr_ready),
      .addr_valid (addr_valid),
      .address    (address),
      .index      (index),
      .last       (last),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always @(posedge clk) begin
      if (reset && enable && addr_valid && addr_ready) xfers++;
   end

   typedef struct {
      logic        start;
      logic        ready;
      logic        en;
      logic        rst;
      logic        exp_valid;
      logic [31:0] exp_addr;
      logic [6:0]  exp_idx;
      logic        exp_last;
      logic        exp_busy;
      logic        exp_done;
      logic        exp_err;
   } vec_t;

   // z_len=8, bases 0/16/32/48, shifts 0/3/7/5; packed {ch3,ch2,ch1,ch0}
   logic [31:0] atab [8];
   vec_t        tab  [$];

   function automatic vec_t mk(input logic st, input logic rdy, input logic v,
                               input int k, input logic l, input logic b, input logic d);
      vec_t r;
      r.start     = st;
      r.ready     = rdy;
      r.en        = 1'b1;
      r.rst       = 1'b1;
      r.exp_valid = v;
      r.exp_addr  = atab[k];
      r.exp_idx   = 7'(k);
      r.exp_last  = l;
      r.exp_busy  = b;
      r.exp_done  = d;
      r.exp_err   = 1'b0;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic st, input logic rdy);
      start      = st;
      addr_ready = rdy;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic cfg_basic();
      z_len     = 7'd8;
      base_addr = {8'd48, 8'd32, 8'd16, 8'd0};
      shift     = {7'd5, 7'd7, 7'd3, 7'd0};
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (3) cyc(1'b0, 1'b0);
      reset = 1'b1;
   endtask

   initial begin
      logic [7:0] fe_exp [4];
      int         x0;
      fe_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      atab = '{{8'd53, 8'd39, 8'd19, 8'd0}, {8'd54, 8'd32, 8'd20, 8'd1},
               {8'd55, 8'd33, 8'd21, 8'd2}, {8'd48, 8'd34, 8'd22, 8'd3},
               {8'd49, 8'd35, 8'd23, 8'd4}, {8'd50, 8'd36, 8'd16, 8'd5},
               {8'd51, 8'd37, 8'd17, 8'd6}, {8'd52, 8'd38, 8'd18, 8'd7}};

      enable = 1'b1; start = 1'b0; addr_ready = 1'b0;
      z_len = '0; base_addr = '0; shift = '0;
`ifdef QC_ADDR_GEN_REVERSE_EN
      reverse = 1'b0;
`endif

      // reset and idle
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1);
         chk("idle.valid", addr_valid, 0);
         chk("idle.busy", busy, 0);
         chk("idle.done", done, 0);
         chk("idle.err", err, 0);
         chk("idle.last", last, 0);
         chk("idle.addr", address, 0);
         chk("idle.index", index, 0);
      end

      // basic sweep followed by the same sweep with backpressure at k=2
      tab.push_back(mk(1, 1, 1, 0, 0, 1, 0));
      for (int k = 1; k < 8; k++) tab.push_back(mk(0, 1, 1, k, k == 7, 1, 0));
      tab.push_back(mk(0, 1, 0, 0, 0, 1, 1));
      tab.push_back(mk(0, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(1, 1, 1, 0, 0, 1, 0));
      tab.push_back(mk(0, 1, 1, 1, 0, 1, 0));
      tab.push_back(mk(0, 1, 1, 2, 0, 1, 0));
      for (int i = 0; i < 4; i++) tab.push_back(mk(1, 0, 1, 2, 0, 1, 0));
      for (int k = 3; k < 8; k++) tab.push_back(mk(0, 1, 1, k, k == 7, 1, 0));
      tab.push_back(mk(0, 1, 0, 0, 0, 1, 1));
      tab.push_back(mk(0, 1, 0, 0, 0, 0, 0));

      cfg_basic();
      x0 = xfers;
      foreach (tab[i]) begin
         enable = tab[i].en;
         reset  = tab[i].rst;
         cyc(tab[i].start, tab[i].ready);
         chk($sformatf("vec%0d.valid", i), addr_valid, tab[i].exp_valid);
         chk($sformatf("vec%0d.busy", i), busy, tab[i].exp_busy);
         chk($sformatf("vec%0d.done", i), done, tab[i].exp_done);
         chk($sformatf("vec%0d.err", i), err, tab[i].exp_err);
         if (tab[i].exp_valid) begin
            chk($sformatf("vec%0d.addr", i), address, tab[i].exp_addr);
            chk($sformatf("vec%0d.index", i), index, tab[i].exp_idx);
            chk($sformatf("vec%0d.last", i), last, tab[i].exp_last);
         end
      end
      chk("transfers", xfers - x0, 16);

      // address wrap past 2^NUM_BITS
      z_len = 7'd4; base_addr = {4{8'hFE}}; shift = '0;
      cyc(1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("wrap%0d.addr", k), address, {4{fe_exp[k]}});
         cyc(1'b0, 1'b1);
      end
      chk("wrap.done", done, 1);
      cyc(1'b0, 1'b1);

      // z_len = 1
      z_len = 7'd1; base_addr = {8'd40, 8'd30, 8'd20, 8'd10}; shift = '0;
      cyc(1'b1, 1'b1);
      chk("z1.valid", addr_valid, 1);
      chk("z1.last", last, 1);
      chk("z1.index", index, 0);
      chk("z1.addr", address, {8'd40, 8'd30, 8'd20, 8'd10});
      cyc(1'b0, 1'b1);
      chk("z1.done", done, 1);
      chk("z1.dvalid", addr_valid, 0);
      cyc(1'b0, 1'b1);
      chk("z1.busy", busy, 0);

      // start ignored in RUN; start in DONE gives one bubble
      z_len = 7'd2; base_addr = {8'd100, 8'd80, 8'd60, 8'd40};
      shift = {7'd1, 7'd0, 7'd1, 7'd0};
      cyc(1'b1, 1'b1);
      chk("b2b.k0", address, {8'd101, 8'd80, 8'd61, 8'd40});
      z_len = 7'd5; base_addr = '0; shift = '0;
      cyc(1'b1, 1'b1);
      chk("b2b.k1", address, {8'd100, 8'd81, 8'd60, 8'd41});
      chk("b2b.last", last, 1);
      cyc(1'b0, 1'b1);
      chk("b2b.bubble", addr_valid, 0);
      chk("b2b.done", done, 1);
      z_len = 7'd2; base_addr = {8'd100, 8'd80, 8'd60, 8'd40};
      shift = {7'd1, 7'd0, 7'd1, 7'd0};
      cyc(1'b1, 1'b1);
      chk("b2b.rvalid", addr_valid, 1);
      chk("b2b.rindex", index, 0);
      chk("b2b.raddr", address, {8'd101, 8'd80, 8'd61, 8'd40});
      repeat (3) cyc(1'b0, 1'b1);
      chk("b2b.idle", busy, 0);

      // enable low mid-sweep freezes everything, including done
      cfg_basic();
      cyc(1'b1, 1'b1);
      repeat (3) cyc(1'b0, 1'b1);
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc(1'(i % 2), 1'b1);
         chk($sformatf("frz%0d.addr", i), address, atab[3]);
         chk($sformatf("frz%0d.index", i), index, 3);
         chk($sformatf("frz%0d.valid", i), addr_valid, 1);
      end
      enable = 1'b1;
      cyc(1'b0, 1'b1);
      chk("frz.resume", address, atab[4]);
      repeat (4) cyc(1'b0, 1'b1);
      chk("frz.done", done, 1);
      enable = 1'b0;
      repeat (2) cyc(1'b0, 1'b1);
      chk("frz.stretch", done, 1);
      enable = 1'b1;
      cyc(1'b0, 1'b1);
      chk("frz.dend", done, 0);
      chk("frz.busy", busy, 0);

      // reset with enable low aborts the sweep
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b1);
      enable = 1'b0; reset = 1'b0;
      cyc(1'b0, 1'b1);
      chk("rst.valid", addr_valid, 0);
      chk("rst.busy", busy, 0);
      chk("rst.addr", address, 0);
      chk("rst.index", index, 0);
      enable = 1'b1; reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 1'b1);
         chk($sformatf("rst%0d.done", i), done, 0);
         chk($sformatf("rst%0d.valid", i), addr_valid, 0);
      end

      // illegal parameters
      z_len = '0; base_addr = '0; shift = '0;
      cyc(1'b1, 1'b1);
      chk("ill.z0valid", addr_valid, 0);
      chk("ill.z0busy", busy, 0);
      chk("ill.z0err", err, 1);
      z_len = 7'd4; shift = {21'd0, 7'd6};
      cyc(1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("ill%0d.ch0", k), address[7:0], k);
         chk($sformatf("ill%0d.err", k), err, 1);
         cyc(1'b0, 1'b1);
      end
      cyc(1'b0, 1'b1);

`ifdef QC_ADDR_GEN_REVERSE_EN
      do_reset();
      reverse = 1'b1; z_len = 7'd4; base_addr = '0; shift = {4{7'd2}};
      cyc(1'b1, 1'b1);
      reverse = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rev%0d.ch0", k), address[7:0], (6 - k) % 4);
         chk($sformatf("rev%0d.index", k), index, k);
         cyc(1'b0, 1'b1);
      end
      chk("rev.err", err, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
